fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch sequencer for the 16-bit single-issue core. It decides every cycle whether the PC register advances, redirects or holds. It also decides whether the IF/ID pipeline register loads, holds or takes a bubble. It arbitrates halt detection, taken-branch redirects from decode, load-use stalls and a multi-cycle instruction memory that requires a stable address while a fetch is outstanding. It sits between the PC logic (selects its next-address source) and instruction memory, and drives the IF/ID register controls.

## Interface
- FLUSH_CYCLES, 1, bubbles inserted after a taken-branch redirect (1..4); the first bubble is the redirect cycle itself
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  fetch request for address currently on PC
- imem_ready  in  1  instruction for current PC valid this cycle
- halt_dec  in  1  decode holds opcode 4'b1111
- br_taken  in  1  decode resolved a taken B/BR this cycle (single-cycle pulse)
- br_target  in  16  redirect address accompanying br_taken
- hazard_stall  in  1  load-use hazard from decode
- pc_wen  out  1  PC register write enable
- pc_sel  out  1  0 = PC+2, 1 = pc_target
- pc_target  out  16  redirect address to PC mux
- if_id_wen  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP instead of fetched word
- halted  out  1  core halted
- stall_cnt  out  16  saturating count of non-advancing cycles

## Operation
- States: RUN, WAIT, FLUSH, HALT. Reset → RUN. Registers: pend_vld, pend_tgt[15:0], flush_cnt[1:0], stall_cnt.
- Priority each cycle: halt_dec > br_taken > hazard_stall > imem_ready.
- RUN, imem_req=1:
  - halt_dec: pc_wen=0, if_id_wen=1, if_id_flush=1 → HALT.
  - br_taken: pc_sel=1, pc_target=br_target, pc_wen=1, if_id_wen=1, if_id_flush=1. Then → FLUSH with flush_cnt=FLUSH_CYCLES−1 if FLUSH_CYCLES>1, else stay RUN.
  - br_taken with imem_ready=0: the outstanding fetch cannot be aborted. pc_wen=0, pend_vld←1, pend_tgt←br_target, bubble → WAIT.
  - hazard_stall (imem_ready=1): pc_wen=0, if_id_wen=0, no flush; the same address is refetched next cycle.
  - imem_ready=0: pc_wen=0, if_id_wen=1, if_id_flush=1 (bubble) → WAIT.
  - else: pc_sel=0, pc_wen=1, if_id_wen=1, if_id_flush=0.
- WAIT, imem_req=1, address held (pc_wen=0), bubble each cycle until imem_ready:
  - br_taken while waiting: capture into pend_tgt / pend_vld (at most one can arrive).
  - imem_ready with pend_vld or br_taken: pc_sel=1, pc_target=br_taken ? br_target : pend_tgt, pc_wen=1, fetched word flushed, pend_vld←0. Then → FLUSH or RUN per FLUSH_CYCLES, as in RUN.
  - imem_ready, no redirect, hazard_stall=0: normal advance → RUN.
  - imem_ready with hazard_stall: hold as in RUN → RUN.
  - halt_dec in WAIT: → HALT immediately, pend_vld←0.
- FLUSH: imem_req=0, pc_wen=0, if_id_wen=1, if_id_flush=1. flush_cnt decrements; at 1 → RUN. halt_dec is ignored (only bubbles are in decode).
- HALT: imem_req=0, pc_wen=0, if_id_wen=0, halted=1. Terminal until reset.
- stall_cnt: increments on every cycle outside HALT with pc_wen=0; saturates at 16'hFFFF and never wraps.
- pc_target = br_target whenever no pending redirect is being applied.

## Timing
- All outputs are combinational from state plus inputs; registers update on the rising clk edge.
- Redirect latency: br_taken in cycle N → PC = target after edge N (RUN with imem_ready=1); first target fetch in N+FLUSH_CYCLES.
- Memory contract: PC is unchanged on every cycle from imem_req assertion until imem_ready.
- Reset mid-operation: asynchronous; all registers clear immediately. Outputs while rst=0: imem_req=0, pc_wen=0, if_id_wen=0, if_id_flush=1, halted=0, stall_cnt=0, pc_sel=0. The first fetch occurs in the cycle after rst rises.

## Test plan
- Straight-line, imem_ready=1 constant, PC starts 16'h0000 → pc_wen=1, pc_sel=0 every cycle; PC 0,2,4,6; stall_cnt stays 0.
- imem_ready low 3 cycles at PC=16'h0010 → pc_wen=0 for 3 cycles, 3 bubbles, PC steps to 16'h0012 on the ready cycle; stall_cnt=3.
- br_taken with br_target=16'h0040 and FLUSH_CYCLES=3, ready=1 → PC=16'h0040 next cycle, then 2 FLUSH cycles with imem_req=0; 3 total bubbles; stall_cnt=2.
- br_taken (target 16'h0080) during WAIT, ready 2 cycles later → PC held, then loads 16'h0080; fetched word flushed; pend_vld cleared.
- halt_dec with simultaneous br_taken → HALT wins: halted=1, PC frozen, imem_req=0 forever. Asserting rst low mid-HALT returns all outputs to reset values at once.
- 70000 cycles with imem_ready=0 → stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC advance/redirect/hold and IF/ID load/bubble control.
// Arbitrates halt, branch redirect, load-use stall and slow imem.
module fetch_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        halt_dec,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        hazard_stall,
  output logic        pc_wen,
  output logic        pc_sel,
  output logic [15:0] pc_target,
  output logic        if_id_wen,
  output logic        if_id_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FLUSH,
    S_HALT
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam state_t REDIR_NEXT =
    (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

  state_t      state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] stall_q;

  logic        req, wen, sel, idw, idf, hlt;
  logic [15:0] tgt;

  // State, pending redirect and flush counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      pend_vld_q  <= 1'b0;
      pend_tgt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_tgt_q  <= pend_tgt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and per-cycle PC / IF-ID controls
  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    flush_cnt_d = flush_cnt_q;
    req = 1'b0;
    wen = 1'b0;
    sel = 1'b0;
    idw = 1'b0;
    idf = 1'b0;
    hlt = 1'b0;
    tgt = br_target;
    unique case (state_q)
      S_RUN: begin
        req = 1'b1;
        if (halt_dec) begin
          idw     = 1'b1;
          idf     = 1'b1;
          state_d = S_HALT;
        end else if (br_taken && imem_ready) begin
          sel         = 1'b1;
          wen         = 1'b1;
          idw         = 1'b1;
          idf         = 1'b1;
          flush_cnt_d = FLUSH_INIT;
          state_d     = REDIR_NEXT;
        end else if (br_taken) begin
          // fetch in flight cannot be aborted
          idw        = 1'b1;
          idf        = 1'b1;
          pend_vld_d = 1'b1;
          pend_tgt_d = br_target;
          state_d    = S_WAIT;
        end else if (hazard_stall) begin
          // hold PC and IF/ID; address stays stable
        end else if (!imem_ready) begin
          idw     = 1'b1;
          idf     = 1'b1;
          state_d = S_WAIT;
        end else begin
          wen = 1'b1;
          idw = 1'b1;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        idw = 1'b1;
        idf = 1'b1;
        if (halt_dec) begin
          pend_vld_d = 1'b0;
          state_d    = S_HALT;
        end else if (imem_ready &&
                     (pend_vld_q || br_taken)) begin
          sel         = 1'b1;
          wen         = 1'b1;
          tgt         = br_taken ? br_target : pend_tgt_q;
          pend_vld_d  = 1'b0;
          flush_cnt_d = FLUSH_INIT;
          state_d     = REDIR_NEXT;
        end else if (br_taken) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = br_target;
        end else if (imem_ready && hazard_stall) begin
          idw     = 1'b0;
          idf     = 1'b0;
          state_d = S_RUN;
        end else if (imem_ready) begin
          wen     = 1'b1;
          idf     = 1'b0;
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        idw         = 1'b1;
        idf         = 1'b1;
        flush_cnt_d = flush_cnt_q - 2'd1;
        if (flush_cnt_q <= 2'd1) begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        hlt = 1'b1;
      end
    endcase
  end

  // Saturating count of cycles where the PC does not advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (state_q != S_HALT && !wen &&
                 stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign imem_req    = rst & req;
  assign pc_wen      = rst & wen;
  assign pc_sel      = rst & sel;
  assign pc_target   = tgt;
  assign if_id_wen   = rst & idw;
  assign if_id_flush = ~rst | idf;
  assign halted      = rst & hlt;
  assign stall_cnt   = stall_q;

endmodule
